// File: rtl/tc_ram_dma.sv
// -----------------------------------------------------------------------------
// tc_ram_dma
//
// Block-copy initiator for a single 256x8 TC RAM port. A command (src, dst,
// len) moves len bytes one at a time: a READ cycle fetches a byte into the
// data register, and the following WRITE cycle stores it at the destination.
// When the destination overlaps the tail of the source, the copy runs from
// the top address downward so that no source byte is overwritten before it
// has been read.
//
// Optional feature (macro TC_RAM_DMA_FILL_EN):
//   When defined, start with fill=1 writes the latched pattern byte to
//   dst..dst+len-1, one byte per cycle, with no reads. When undefined, fill
//   and pattern are ignored and every command is a copy.
//
// Handshake: start is a level sampled at a posedge only while IDLE; the
// command inputs are latched at that edge and are don't-care afterwards.
// busy is high for the whole transfer, and done pulses for exactly one cycle
// after the last write. There is no back-pressure.
//
// Ports:
//   clk          in   clock, all state changes on posedge
//   rst          in   synchronous active-low reset
//   start        in   command strobe (IDLE only)
//   fill         in   1 = fill mode (with TC_RAM_DMA_FILL_EN), 0 = copy
//   src          in   [7:0] copy source base address
//   dst          in   [7:0] destination base address
//   len          in   [7:0] byte count, 0 = no-op
//   pattern      in   [7:0] fill byte
//   busy         out  transfer in progress (READ/WRITE/FILL)
//   done         out  one-cycle completion pulse
//   ram_load     out  RAM read enable
//   ram_save     out  RAM write enable (RAM commits at the negedge)
//   ram_address  out  [7:0] RAM address
//   ram_in       out  [7:0] RAM write data
//   ram_out      in   [7:0] RAM combinational read data
//
// All outputs are decoded from registered state only (Moore); nothing on
// the command inputs reaches the RAM port combinationally.
// -----------------------------------------------------------------------------
module tc_ram_dma #(
  parameter int    UUID = 0,
  parameter string NAME = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       fill,
  input  logic [7:0] src,
  input  logic [7:0] dst,
  input  logic [7:0] len,
  input  logic [7:0] pattern,
  output logic       busy,
  output logic       done,
  output logic       ram_load,
  output logic       ram_save,
  output logic [7:0] ram_address,
  output logic [7:0] ram_in,
  input  logic [7:0] ram_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
`ifdef TC_RAM_DMA_FILL_EN
    S_FILL  = 3'd4,
`endif
    S_DONE  = 3'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] src_q,   src_d;    // current source address
  logic [7:0] dst_q,   dst_d;    // current destination address
  logic [7:0] rem_q,   rem_d;    // bytes still to be written
  logic [7:0] data_q,  data_d;   // byte in flight (or fill pattern)
  logic       desc_q,  desc_d;   // 1 = addresses step downward

  // Identification parameters carry no logic.
  logic unused_cfg;
  assign unused_cfg = (UUID == 0) ^ (NAME == "");

`ifndef TC_RAM_DMA_FILL_EN
  logic unused_fill;
  assign unused_fill = fill ^ (^pattern);
`endif

  // Overlap test at command time: if dst lies inside [src, src+len) (mod
  // 256), an ascending copy would clobber unread source bytes, so run from
  // the top down. dst == src is a harmless self-copy and stays ascending.
  logic [7:0] cmd_gap;
  logic       cmd_desc;
  assign cmd_gap  = dst - src;
  assign cmd_desc = (dst != src) && (cmd_gap < len);

  // Address step: +1 ascending, -1 (0xFF, 8-bit wrap) descending.
  logic [7:0] step;
  assign step = desc_q ? 8'hFF : 8'h01;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    desc_d  = desc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          desc_d = cmd_desc;
          src_d  = cmd_desc ? (src + len - 8'd1) : src;
          dst_d  = cmd_desc ? (dst + len - 8'd1) : dst;
          rem_d  = len;
`ifdef TC_RAM_DMA_FILL_EN
          // The pattern is held in the data register so the RAM write
          // data never comes straight from a command input.
          data_d = pattern;
`else
          data_d = 8'h00;
`endif
          if (len == 8'd0) begin
            state_d = S_DONE;
`ifdef TC_RAM_DMA_FILL_EN
          end else if (fill) begin
            state_d = S_FILL;
`endif
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        data_d  = ram_out;
        state_d = S_WRITE;
      end

      S_WRITE: begin
        src_d   = src_q + step;
        dst_d   = dst_q + step;
        rem_d   = rem_q - 8'd1;
        state_d = (rem_q == 8'd1) ? S_DONE : S_READ;
      end

`ifdef TC_RAM_DMA_FILL_EN
      S_FILL: begin
        dst_d   = dst_q + step;
        rem_d   = rem_q - 8'd1;
        state_d = (rem_q == 8'd1) ? S_DONE : S_FILL;
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      src_q   <= 8'h00;
      dst_q   <= 8'h00;
      rem_q   <= 8'h00;
      data_q  <= 8'h00;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      desc_q  <= desc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (state only). load and save are decoded from disjoint
  // states, so they can never be high together.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    ram_load    = 1'b0;
    ram_save    = 1'b0;
    ram_address = 8'h00;
    ram_in      = 8'h00;

    case (state_q)
      S_READ: begin
        busy        = 1'b1;
        ram_load    = 1'b1;
        ram_address = src_q;
      end
      S_WRITE: begin
        busy        = 1'b1;
        ram_save    = 1'b1;
        ram_address = dst_q;
        ram_in      = data_q;
      end
`ifdef TC_RAM_DMA_FILL_EN
      S_FILL: begin
        busy        = 1'b1;
        ram_save    = 1'b1;
        ram_address = dst_q;
        ram_in      = data_q;
      end
`endif
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_tc_ram_dma.sv
// -----------------------------------------------------------------------------
// tb_tc_ram_dma
//
// Bench for tc_ram_dma with a behavioural 256x8 RAM (combinational read,
// write committed at the negedge while ram_save is high). Expected results
// come from a memmove-style model: the source bytes are snapshotted before
// the command, the destination receives them, and the write order follows
// the overlap rule. Every cycle of every command is compared against the
// expected port activity, then the observed write log and the whole RAM
// image are compared against the model.
// -----------------------------------------------------------------------------
module tb_tc_ram_dma;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start, fill;
  logic [7:0] src, dst, len, pattern;
  logic       busy, done, ram_load, ram_save;
  logic [7:0] ram_address, ram_in, ram_out;

  tc_ram_dma #(.UUID(0), .NAME("dut")) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .fill        (fill),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .pattern     (pattern),
    .busy        (busy),
    .done        (done),
    .ram_load    (ram_load),
    .ram_save    (ram_save),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_out     (ram_out)
  );

  // ---------------------------------------------------------------------------
  // RAM model: one writer process for the array (DUT writes + image loads)
  // ---------------------------------------------------------------------------
  logic [7:0]  mem      [256];
  logic [7:0]  init_img [256];
  logic        load_img = 1'b0;
  logic [15:0] act_q [$];   // observed writes {addr, data}

  assign ram_out = mem[ram_address];

  always @(negedge clk) begin
    if (load_img) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_img[i];
    end else if (ram_save) begin
      mem[ram_address] <= ram_in;
      act_q.push_back({ram_address, ram_in});
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q [$];   // expected writes {addr, data}, in order
  logic [7:0]  exp_mem [256];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // {busy, done, ram_load, ram_save, ram_address, ram_in}
  function automatic logic [19:0] obs_vec();
    return {busy, done, ram_load, ram_save, ram_address, ram_in};
  endfunction

  function automatic logic [19:0] mk_vec(input logic b, input logic d,
                                         input logic l, input logic s,
                                         input logic [7:0] a,
                                         input logic [7:0] w);
    return {b, d, l, s, a, w};
  endfunction

  task automatic check_log_and_mem(input string tag);
    logic [15:0] e, a;
    int nd;
    check({tag, "_nwr"}, act_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (act_q.size() > 0) a = act_q.pop_front();
      else a = 16'hxxxx;
      check({tag, "_wr"}, a, e);
    end
    act_q.delete();
    nd = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) nd++;
    check({tag, "_memdiff"}, nd, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (all entered and left at #1 after a posedge)
  // ---------------------------------------------------------------------------
  task automatic preload();
    load_img = 1'b1;
    @(negedge clk);
    #1 load_img = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_cmd_inputs();
    fill    = 1'($urandom);
    src     = 8'($urandom);
    dst     = 8'($urandom);
    len     = 8'($urandom);
    pattern = 8'($urandom);
  endtask

  // Issue one command and check every cycle up to and including done.
  task automatic run_cmd(input string tag, input logic fill_i,
                         input logic [7:0] src_i, input logic [7:0] dst_i,
                         input logic [7:0] len_i, input logic [7:0] pat_i,
                         input bit glitch);
    logic [7:0]  snap [256];
    logic [7:0]  gap;
    logic [19:0] ev, ov;
    bit          is_fill, desc;
    int          n, cycles, j, k;

    n = int'(len_i);
`ifdef TC_RAM_DMA_FILL_EN
    is_fill = fill_i;
`else
    is_fill = 1'b0;
`endif
    gap  = dst_i - src_i;
    desc = (dst_i != src_i) && (gap < len_i);

    // Model: memmove from a snapshot of the source.
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    for (int i = 0; i < n; i++) snap[i] = mem[8'(src_i + i)];
    exp_q.delete();
    act_q.delete();
    for (int i = 0; i < n; i++) begin
      if (is_fill) begin
        exp_q.push_back({8'(dst_i + i), pat_i});
        exp_mem[8'(dst_i + i)] = pat_i;
      end else begin
        k = desc ? (n - 1 - i) : i;
        exp_q.push_back({8'(dst_i + k), snap[k]});
        exp_mem[8'(dst_i + k)] = snap[k];
      end
    end
    cycles = is_fill ? (n + 1) : (2 * n + 1);

    start = 1'b1; fill = fill_i; src = src_i; dst = dst_i;
    len = len_i; pattern = pat_i;
    @(posedge clk);               // edge 0
    #1;
    start = 1'b0;
    randomize_cmd_inputs();       // latched values must be used from now on

    for (int c = 1; c <= cycles; c++) begin
      ov = obs_vec();
      if (c == cycles) begin
        ev = mk_vec(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      end else if (is_fill) begin
        ev = mk_vec(1'b1, 1'b0, 1'b0, 1'b1, 8'(dst_i + c - 1), pat_i);
      end else begin
        j = (c - 1) / 2;
        k = desc ? (n - 1 - j) : j;
        if (c % 2 == 1) begin
          ev = mk_vec(1'b1, 1'b0, 1'b1, 1'b0, 8'(src_i + k), 8'h00);
          ov[7:0] = 8'h00;        // write data is not defined on a read
        end else begin
          ev = mk_vec(1'b1, 1'b0, 1'b0, 1'b1, 8'(dst_i + k), snap[k]);
        end
      end
      check($sformatf("%s_cyc%0d", tag, c), ov, ev);
      if (glitch && c == 2) begin
        randomize_cmd_inputs();
        len   = 8'($urandom_range(1, 255));
        start = 1'b1;
      end
      if (glitch && c == 3) start = 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check_log_and_mem(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] rs, rd, rl;
    logic       rf;
    string      rtag;

    rst = 1'b0; start = 1'b0; fill = 1'b0;
    src = 8'h00; dst = 8'h00; len = 8'h00; pattern = 8'h00;

    // Reset values, held in reset across several edges.
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", obs_vec(), 20'h0);

    for (int i = 0; i < 256; i++) init_img[i] = 8'($urandom);
    init_img[8'h10] = 8'h11; init_img[8'h11] = 8'h22;
    init_img[8'h12] = 8'h33; init_img[8'h13] = 8'h44;
    init_img[8'h40] = 8'h01; init_img[8'h41] = 8'h02;
    init_img[8'h42] = 8'h03; init_img[8'h43] = 8'h04;
    init_img[8'hFE] = 8'h0A; init_img[8'hFF] = 8'h0B;
    init_img[8'h00] = 8'h0C; init_img[8'h01] = 8'h0D;
    preload();
    check("reset_outs_held", obs_vec(), 20'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_outs", obs_vec(), 20'h0);

    // Directed commands, issued back-to-back.
    run_cmd("asc",     1'b0, 8'h10, 8'h20, 8'd4, 8'h00, 1'b0);
    check("asc_data3", mem[8'h23], 8'h44);
    run_cmd("overlap", 1'b0, 8'h40, 8'h41, 8'd4, 8'h00, 1'b0);
    check("overlap_data", {mem[8'h41], mem[8'h42], mem[8'h43], mem[8'h44]},
          32'h01020304);
    run_cmd("wrap",    1'b0, 8'hFE, 8'h02, 8'd4, 8'h00, 1'b0);
    check("wrap_data", {mem[8'h02], mem[8'h03], mem[8'h04], mem[8'h05]},
          32'h0A0B0C0D);
    run_cmd("len0",    1'b0, 8'h33, 8'h77, 8'd0, 8'h00, 1'b0);
    run_cmd("guard",   1'b0, 8'h60, 8'h70, 8'd4, 8'h00, 1'b1);

    // Reset in the middle of a len=4 copy: rst low at edge 3.
    exp_q.delete();
    act_q.delete();
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    exp_mem[8'h50] = mem[8'h30];
    exp_q.push_back({8'h50, mem[8'h30]});
    start = 1'b1; fill = 1'b0; src = 8'h30; dst = 8'h50; len = 8'd4;
    @(posedge clk);
    #1 start = 1'b0;
    check("rstmid_c1", obs_vec(), mk_vec(1, 0, 1, 0, 8'h30, ram_in));
    @(posedge clk);
    #1;
    check("rstmid_c2", obs_vec(), mk_vec(1, 0, 0, 1, 8'h50, mem[8'h30]));
    @(posedge clk);
    #1;
    check("rstmid_c3", obs_vec(), mk_vec(1, 0, 1, 0, 8'h31, ram_in));
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 4; c <= 8; c++) begin
      check($sformatf("rstmid_quiet%0d", c), obs_vec(), 20'h0);
      @(posedge clk);
      #1;
    end
    check_log_and_mem("rstmid");

    // Fill command (a copy from src when the feature is compiled out).
    run_cmd("fill", 1'b1, 8'h10, 8'h80, 8'd3, 8'h5A, 1'b0);
`ifdef TC_RAM_DMA_FILL_EN
    check("fill_data", {mem[8'h80], mem[8'h81], mem[8'h82]}, 24'h5A5A5A);
`else
    check("fill_as_copy", {mem[8'h80], mem[8'h81], mem[8'h82]}, 24'h112233);
`endif

    // Randomized commands. len <= 128 keeps the source and destination from
    // overlapping at both ends, so the memmove model is exact.
    for (int t = 0; t < 24; t++) begin
      if (t % 6 == 0) begin
        for (int i = 0; i < 256; i++) init_img[i] = 8'($urandom);
        preload();
      end
      rs = 8'($urandom);
      if ($urandom_range(0, 1) == 1) rd = 8'(rs + $urandom_range(0, 8) - 4);
      else rd = 8'($urandom);
      rl = 8'($urandom_range(0, 128));
      if (t % 8 == 3) rl = 8'd1;
      rf = ($urandom_range(0, 3) == 0);
      rtag = $sformatf("rnd%0d", t);
      run_cmd(rtag, rf, rs, rd, rl, 8'($urandom), (rl >= 8'd2) && ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tc_ram_dma.md
# tc_ram_dma

Block-copy initiator that drives the load/save/address/in/out port of a 256x8 TC RAM. Given a source, destination and length, it moves bytes one at a time through a read cycle and a write cycle. It sits between a control FSM or CPU and a single RAM instance, and owns that RAM's port while busy. Overlapping regions are copied in the direction that preserves source data. An optional constant-fill mode is also provided.

## Interface
Parameters:
- UUID, 0, instance identifier (unused in logic)
- NAME, "", instance name (unused in logic)

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-low (rst=0 at a posedge resets)
- start  in  1  command strobe, sampled only in IDLE
- fill  in  1  1 = fill mode (only with macro), 0 = copy
- src  in  8  copy source base address
- dst  in  8  destination base address
- len  in  8  byte count; 0 = no-op
- pattern  in  8  fill byte
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- ram_load  out  1  to RAM load
- ram_save  out  1  to RAM save
- ram_address  out  8  to RAM address
- ram_in  out  8  to RAM in (write data)
- ram_out  in  8  from RAM out (combinational read data)

## Operation
- States: IDLE, READ, WRITE, FILL, DONE.
- IDLE to READ when start=1 and len!=0. IDLE to FILL when start=1, len!=0, fill=1 and the macro is defined. IDLE to DONE when start=1 and len=0.
- At start, latch the following: cur_src, cur_dst, remaining=len, data register, and direction.
- Direction is descending when dst!=src and ((dst-src) mod 256) < len. Otherwise it is ascending.
- Descending start addresses are src+len-1 and dst+len-1, computed mod 256.
- READ: ram_load=1, ram_address=cur_src. At the posedge, capture ram_out into the data register and go to WRITE.
- WRITE: ram_save=1, ram_address=cur_dst, ram_in=data. The RAM commits the write at the following negedge.
  - At the posedge: step cur_src and cur_dst by ±1 (8-bit wrap) and decrement remaining.
  - Go to DONE if remaining was 1, otherwise go to READ.
- FILL: ram_save=1, ram_address=cur_dst, ram_in=pattern. Step and decrement every cycle; go to DONE after the last byte.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in READ, WRITE and FILL only.
- start is ignored outside IDLE. Command inputs are don't-care after being latched.
- In IDLE and DONE: ram_load=0, ram_save=0, ram_address=0, ram_in=0.
- ram_load and ram_save are never both 1.
- Reset (rst=0 at a posedge):
  - State goes to IDLE and all outputs go to 0; no done pulse.
  - A write already in its WRITE/FILL cycle before that posedge completes at its negedge.
  - Nothing further is issued.

## Timing
- Reset values: busy=0, done=0, ram_load=0, ram_save=0, ram_address=0x00, ram_in=0x00.
- Start is sampled at edge 0. Cycle n is the cycle following edge n-1.
- Copy of N bytes:
  - Byte k (k=1..N) is read in cycle 2k-1 and written in cycle 2k.
  - done is high in cycle 2N+1, with busy=0.
  - Back-to-back start is accepted at edge 2N+2.
- Fill of N bytes: byte k is written in cycle k; done is high in cycle N+1.
- len=0: done in cycle 1, with no RAM access.
- len is 8 bits, so the maximum transfer is 255 bytes.
- All outputs are registered-state decodes (Moore). There is no combinational path from start or the command inputs to the RAM port.

## Configuration
- TC_RAM_DMA_FILL_EN defined: the FILL state and pattern path exist, and fill=1 selects fill mode.
- TC_RAM_DMA_FILL_EN undefined:
  - No FILL state.
  - The fill and pattern inputs are ignored; fill is treated as 0, so every command is a copy.
  - ram_in is driven only from the data register.

## Test plan
- Copy, ascending: RAM[0x10..0x13]=11,22,33,44; src=0x10, dst=0x20, len=4 → RAM[0x20..0x23]=11,22,33,44; done in cycle 9; busy high cycles 1-8.
- Copy, overlap forward: RAM[0x40..0x43]=1,2,3,4; src=0x40, dst=0x41, len=4 → descending addresses 0x43/0x44 first; RAM[0x41..0x44]=1,2,3,4.
- Copy, wrap: src=0xFE, dst=0x02, len=4 with RAM[FE,FF,00,01]=A,B,C,D → RAM[02..05]=A,B,C,D.
- Zero length and busy guard: len=0 → done in cycle 1, ram_load and ram_save never high. During a len=4 copy, pulse start with other operands → ignored; result unchanged.
- Reset mid-copy: rst=0 at edge 3 of a len=4 copy → from the next cycle busy=0, no done, no further ram_save; only byte 1 written.
- Fill (with TC_RAM_DMA_FILL_EN): dst=0x80, len=3, pattern=0x5A → RAM[0x80..0x82]=5A; done in cycle 4. Same command without the macro performs a copy from src.
